// File: rtl/mont_pkg.sv
// Shared types and sizing helpers for the Montgomery constant streamer.
package mont_pkg;

   localparam int DATA_WIDTH_DEF  = 32;
   localparam int DATA_LENGTH_DEF = 1024;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_LOAD,
      ST_STREAM,
      ST_FINISH
   } state_t;

   function automatic int num_words(input int data_length, input int data_width);
      return data_length / data_width;
   endfunction

   // Index width never drops below one bit, even for a single-word stream.
   function automatic int idx_width(input int nwords);
      return (nwords > 1) ? $clog2(nwords) : 1;
   endfunction

endpackage

// File: rtl/mont_const_streamer_if.sv
// Word stream from the streamer to the downstream loader (valid/ready).
interface mont_const_streamer_if #(
   parameter int DATA_WIDTH  = mont_pkg::DATA_WIDTH_DEF,
   parameter int DATA_LENGTH = mont_pkg::DATA_LENGTH_DEF
);
   localparam int IDX_W = mont_pkg::idx_width(mont_pkg::num_words(DATA_LENGTH, DATA_WIDTH));

   logic                  word_valid;
   logic                  word_ready;
   logic [DATA_WIDTH-1:0] r_word;
   logic [DATA_WIDTH-1:0] t_word;
   logic [IDX_W-1:0]      word_idx;
   logic                  word_last;

   modport master (
      output word_valid, r_word, t_word, word_idx, word_last,
      input  word_ready
   );

   modport slave (
      input  word_valid, r_word, t_word, word_idx, word_last,
      output word_ready
   );

endinterface

// File: rtl/mont_word_serializer.sv
// Holds r and t as a shift-register pair and presents one word of each per
// handshake, in MSW-first or LSW-first order, with a stream-order index.
module mont_word_serializer
   import mont_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int DATA_LENGTH = DATA_LENGTH_DEF,
   parameter bit MSW_FIRST   = 1'b1,
   localparam int NUM_WORDS  = num_words(DATA_LENGTH, DATA_WIDTH),
   localparam int IDX_W      = idx_width(NUM_WORDS)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   advance,
   input  logic [DATA_LENGTH-1:0] r_i,
   input  logic [DATA_LENGTH-1:0] t_i,
   output logic [DATA_WIDTH-1:0]  r_word,
   output logic [DATA_WIDTH-1:0]  t_word,
   output logic [IDX_W-1:0]       word_idx,
   output logic                   word_last
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

   logic [DATA_LENGTH-1:0] r_sr_q, r_sr_d;
   logic [DATA_LENGTH-1:0] t_sr_q, t_sr_d;
   logic [IDX_W-1:0]       idx_q,  idx_d;

   // The current word always sits at the end the shift moves away from.
   function automatic logic [DATA_LENGTH-1:0] shift_word(input logic [DATA_LENGTH-1:0] v);
      return MSW_FIRST ? (v << DATA_WIDTH) : (v >> DATA_WIDTH);
   endfunction

   always_comb begin
      r_sr_d = r_sr_q;
      t_sr_d = t_sr_q;
      idx_d  = idx_q;
      if (load) begin
         r_sr_d = r_i;
         t_sr_d = t_i;
         idx_d  = '0;
      end else if (advance) begin
         r_sr_d = shift_word(r_sr_q);
         t_sr_d = shift_word(t_sr_q);
         idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr_q <= '0;
         t_sr_q <= '0;
         idx_q  <= '0;
      end else begin
         r_sr_q <= r_sr_d;
         t_sr_q <= t_sr_d;
         idx_q  <= idx_d;
      end
   end

   assign r_word    = MSW_FIRST ? r_sr_q[DATA_LENGTH-1 -: DATA_WIDTH] : r_sr_q[DATA_WIDTH-1:0];
   assign t_word    = MSW_FIRST ? t_sr_q[DATA_LENGTH-1 -: DATA_WIDTH] : t_sr_q[DATA_WIDTH-1:0];
   assign word_idx  = idx_q;
   assign word_last = (idx_q == LAST_IDX);

endmodule

// File: rtl/mont_const_streamer.sv
// Sequences the n0prime and r/t engines for one modulus, captures their
// results and streams r/t word pairs to the loader under backpressure.
module mont_const_streamer
   import mont_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int DATA_LENGTH    = DATA_LENGTH_DEF,
   parameter bit MSW_FIRST      = 1'b1,
   parameter int TIMEOUT_CYCLES = 4096
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic                   eng_start,
   input  logic                   n0p_done_i,
   input  logic                   rt_done_i,
   input  logic [DATA_WIDTH-1:0]  n0p_i,
   input  logic [DATA_LENGTH-1:0] r_i,
   input  logic [DATA_LENGTH-1:0] t_i,
   output logic [DATA_WIDTH-1:0]  n0p,
   mont_const_streamer_if.master  ws,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout_err
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t                state_q, state_d;
   logic                  n0p_flag_q, n0p_flag_d;
   logic                  rt_flag_q, rt_flag_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  eng_start_q, eng_start_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [DATA_WIDTH-1:0] n0p_q, n0p_d;

   logic n0p_seen, rt_seen;
   logic ser_load, ser_advance, ser_last;

   assign n0p_seen    = n0p_flag_q | n0p_done_i;
   assign rt_seen     = rt_flag_q  | rt_done_i;
   assign ser_advance = valid_q & ws.word_ready;

   always_comb begin
      state_d       = state_q;
      n0p_flag_d    = n0p_flag_q;
      rt_flag_d     = rt_flag_q;
      cnt_d         = cnt_q;
      n0p_d         = n0p_q;
      timeout_err_d = 1'b0;
      ser_load      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Engine done pulses outside a run are deliberately dropped.
         end
         ST_LAUNCH: begin
            cnt_d      = '0;
            n0p_flag_d = n0p_seen;
            rt_flag_d  = rt_seen;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            n0p_flag_d = n0p_seen;
            rt_flag_d  = rt_seen;
            cnt_d      = cnt_q + CNT_W'(1);
            if (n0p_seen && rt_seen) begin
               state_d = ST_LOAD;
            end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
               state_d       = ST_IDLE;
               timeout_err_d = 1'b1;
            end
         end
         ST_LOAD: begin
            ser_load = 1'b1;
            n0p_d    = n0p_i;
            state_d  = ST_STREAM;
         end
         ST_STREAM: begin
            if (ser_advance && ser_last) state_d = ST_FINISH;
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A start in any state (re)launches; the abandoned run yields nothing.
      if (start) begin
         state_d       = ST_LAUNCH;
         n0p_flag_d    = 1'b0;
         rt_flag_d     = 1'b0;
         n0p_d         = n0p_q;
         ser_load      = 1'b0;
         timeout_err_d = 1'b0;
      end

      eng_start_d = (state_d == ST_LAUNCH);
      valid_d     = (state_d == ST_STREAM);
      done_d      = (state_d == ST_FINISH);
      busy_d      = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         n0p_flag_q    <= 1'b0;
         rt_flag_q     <= 1'b0;
         cnt_q         <= '0;
         eng_start_q   <= 1'b0;
         valid_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
         n0p_q         <= '0;
      end else begin
         state_q       <= state_d;
         n0p_flag_q    <= n0p_flag_d;
         rt_flag_q     <= rt_flag_d;
         cnt_q         <= cnt_d;
         eng_start_q   <= eng_start_d;
         valid_q       <= valid_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
         n0p_q         <= n0p_d;
      end
   end

   mont_word_serializer #(
      .DATA_WIDTH  (DATA_WIDTH),
      .DATA_LENGTH (DATA_LENGTH),
      .MSW_FIRST   (MSW_FIRST)
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (ser_load),
      .advance   (ser_advance),
      .r_i       (r_i),
      .t_i       (t_i),
      .r_word    (ws.r_word),
      .t_word    (ws.t_word),
      .word_idx  (ws.word_idx),
      .word_last (ser_last)
   );

   assign ws.word_valid = valid_q;
   assign ws.word_last  = valid_q & ser_last;
   assign eng_start     = eng_start_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign timeout_err   = timeout_err_q;
   assign n0p           = n0p_q;

endmodule

// File: tb/tb_mont_const_streamer.sv
// Directed and randomized bench: one MSW-first instance (short timeout) and one
// LSW-first instance share stimulus; a word-order model supplies expectations.
module tb_mont_const_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        n0p_done_i, rt_done_i;
   logic [7:0]  n0p_i;
   logic [31:0] r_i, t_i;
   logic        word_ready;

   logic       eng_a, busy_a, done_a, to_a;
   logic       eng_b, busy_b, done_b, to_b;
   logic [7:0] n0p_a, n0p_b;

   int n_chk  = 0;
   int n_fail = 0;
   bit sel    = 1'b0;

   logic       o_valid, o_last, o_eng, o_busy, o_done, o_to;
   logic [7:0] o_rw, o_tw, o_n0p;
   logic [1:0] o_idx;

   always #5 clk = ~clk;

   mont_const_streamer_if #(.DATA_WIDTH(8), .DATA_LENGTH(32)) ifa ();
   mont_const_streamer_if #(.DATA_WIDTH(8), .DATA_LENGTH(32)) ifb ();
   assign ifa.word_ready = word_ready;
   assign ifb.word_ready = word_ready;

   mont_const_streamer #(.DATA_WIDTH(8), .DATA_LENGTH(32), .MSW_FIRST(1'b1), .TIMEOUT_CYCLES(16)) dut_a (
      .clk(clk), .rst(rst), .start(start), .eng_start(eng_a),
      .n0p_done_i(n0p_done_i), .rt_done_i(rt_done_i), .n0p_i(n0p_i),
      .r_i(r_i), .t_i(t_i), .n0p(n0p_a), .ws(ifa),
      .busy(busy_a), .done(done_a), .timeout_err(to_a));

   mont_const_streamer #(.DATA_WIDTH(8), .DATA_LENGTH(32), .MSW_FIRST(1'b0), .TIMEOUT_CYCLES(64)) dut_b (
      .clk(clk), .rst(rst), .start(start), .eng_start(eng_b),
      .n0p_done_i(n0p_done_i), .rt_done_i(rt_done_i), .n0p_i(n0p_i),
      .r_i(r_i), .t_i(t_i), .n0p(n0p_b), .ws(ifb),
      .busy(busy_b), .done(done_b), .timeout_err(to_b));

   always_comb begin
      o_valid = sel ? ifb.word_valid : ifa.word_valid;
      o_last  = sel ? ifb.word_last  : ifa.word_last;
      o_rw    = sel ? ifb.r_word     : ifa.r_word;
      o_tw    = sel ? ifb.t_word     : ifa.t_word;
      o_idx   = sel ? ifb.word_idx   : ifa.word_idx;
      o_eng   = sel ? eng_b  : eng_a;
      o_busy  = sel ? busy_b : busy_a;
      o_done  = sel ? done_b : done_a;
      o_to    = sel ? to_b   : to_a;
      o_n0p   = sel ? n0p_b  : n0p_a;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Word k in stream order: MSW-first counts down from the top byte.
   function automatic logic [7:0] model_word(input logic [31:0] v, input int k, input bit lsw_first);
      int pos;
      pos = lsw_first ? k : 3 - k;
      return 8'((v >> (8 * pos)) & 32'hFF);
   endfunction

   task automatic chk_reset(input string tag);
      chk({tag, "_a_ctl"}, {26'd0, eng_a, busy_a, done_a, to_a, ifa.word_valid, ifa.word_last}, 32'd0);
      chk({tag, "_a_dat"}, {6'd0, n0p_a, ifa.r_word, ifa.t_word, ifa.word_idx}, 32'd0);
      chk({tag, "_b_ctl"}, {26'd0, eng_b, busy_b, done_b, to_b, ifb.word_valid, ifb.word_last}, 32'd0);
      chk({tag, "_b_dat"}, {6'd0, n0p_b, ifb.r_word, ifb.t_word, ifb.word_idx}, 32'd0);
   endtask

   // Call at posedge+1; start is driven in this cycle (cycle 0 of the run).
   // rmode: 0 ready always, 1 ready every third cycle, 2 random ready.
   task automatic run_txn(input bit s, input logic [31:0] r, input logic [31:0] t,
                          input logic [7:0] n, input int c_rt, input int c_n0p,
                          input int rmode, input int abort_after, input string tag);
      int hs, dn, done_cy, last_hs_cy, first_v, load_cy, c_both;
      bit ab;
      sel = s; start = 1'b1; r_i = r; t_i = t; n0p_i = n;
      n0p_done_i = 1'b0; rt_done_i = 1'b0;
      c_both  = (c_rt > c_n0p) ? c_rt : c_n0p;
      load_cy = (c_both < 2) ? 3 : c_both + 1;
      hs = 0; dn = 0; done_cy = -1; last_hs_cy = -1; first_v = -1; ab = 1'b0;
      for (int cy = 1; cy <= 100; cy++) begin
         @(posedge clk); #1;
         start      = 1'b0;
         n0p_done_i = (cy == c_n0p);
         rt_done_i  = (cy == c_rt);
         case (rmode)
            0:       word_ready = 1'b1;
            1:       word_ready = (cy % 3 == 0);
            default: word_ready = 1'($urandom_range(0, 1));
         endcase
         chk({tag, "_eng_start"}, o_eng, (cy == 1));
         if (cy <= load_cy) chk({tag, "_valid_early"}, o_valid, 1'b0);
         if (o_valid) begin
            if (first_v < 0) first_v = cy;
            chk({tag, "_no_extra_word"}, (hs < 4), 1'b1);
            if (hs < 4) begin
               chk({tag, "_r_word"}, o_rw, model_word(r, hs, s));
               chk({tag, "_t_word"}, o_tw, model_word(t, hs, s));
               chk({tag, "_word_idx"}, o_idx, hs);
               chk({tag, "_word_last"}, o_last, (hs == 3));
            end
            if (word_ready) begin
               hs++;
               last_hs_cy = cy;
               if (abort_after > 0 && hs == abort_after) begin
                  ab = 1'b1;
                  break;
               end
            end
         end
         if (o_done) begin
            dn++;
            if (done_cy < 0) done_cy = cy;
         end
         if (done_cy > 0 && cy >= done_cy + 2) break;
      end
      if (ab) begin
         chk({tag, "_no_done_before_abort"}, dn, 0);
      end else begin
         chk({tag, "_handshakes"}, hs, 4);
         chk({tag, "_done_count"}, dn, 1);
         chk({tag, "_done_after_last"}, done_cy, last_hs_cy + 1);
         chk({tag, "_first_valid"}, first_v, load_cy + 1);
         chk({tag, "_n0p"}, o_n0p, n);
         chk({tag, "_busy_end"}, o_busy, 1'b0);
         if (rmode == 0) chk({tag, "_done_cycle"}, done_cy, load_cy + 5);
      end
   endtask

   initial begin
      int to_cnt, to_cy, v_seen;
      rst = 1'b1; start = 1'b0; n0p_done_i = 1'b0; rt_done_i = 1'b0;
      n0p_i = '0; r_i = '0; t_i = '0; word_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Nominal MSW-first: dones together at cycle 10, done at 16.
      run_txn(1'b0, 32'hA1B2C3D4, 32'h11223344, 8'h5F, 10, 10, 0, 0, "nominal");

      // Timeout on the 16-cycle instance: only n0p_done arrives.
      sel = 1'b0; start = 1'b1; n0p_i = 8'hE7; to_cnt = 0; to_cy = -1; v_seen = 0;
      for (int cy = 1; cy <= 30; cy++) begin
         @(posedge clk); #1;
         start = 1'b0;
         n0p_done_i = (cy == 3);
         rt_done_i  = 1'b0;
         if (o_to) begin
            to_cnt++;
            if (to_cy < 0) to_cy = cy;
         end
         if (o_valid) v_seen++;
         if (cy == 18) chk("timeout_busy_drop", o_busy, 1'b0);
      end
      n0p_done_i = 1'b0;
      chk("timeout_pulses", to_cnt, 1);
      chk("timeout_cycle", to_cy, 18);
      chk("timeout_no_valid", v_seen, 0);
      chk("timeout_n0p_kept", o_n0p, 8'h5F);

      // LSW-first, staggered engine completion.
      run_txn(1'b1, 32'hA1B2C3D4, 32'h11223344, 8'h3C, 5, 20, 0, 0, "lsw_first");

      // Backpressure on both word orders.
      run_txn(1'b0, 32'hA1B2C3D4, 32'h11223344, 8'h71, 4, 4, 1, 0, "bp_msw");
      run_txn(1'b1, 32'h0F1E2D3C, 32'hF0E1D2C3, 8'h82, 4, 6, 1, 0, "bp_lsw");

      // Abort after two words, then a complete fresh run.
      run_txn(1'b0, 32'hDEADBEEF, 32'hCAFEF00D, 8'h19, 3, 3, 0, 2, "abort_first");
      run_txn(1'b0, 32'h01234567, 32'h89ABCDEF, 8'h2A, 4, 5, 0, 0, "abort_rerun");

      // Randomized runs on both instances.
      for (int i = 0; i < 8; i++) begin
         run_txn(1'(i % 2), $urandom, $urandom, 8'($urandom),
                 $urandom_range(1, 12), $urandom_range(1, 12), 2, 0, "random");
      end

      // Asynchronous reset mid-stream, then a normal run.
      run_txn(1'b0, 32'h55AA33CC, 32'h0FF0F00F, 8'h66, 3, 3, 1, 2, "pre_async");
      #3 rst = 1'b1;
      #1;
      chk_reset("async_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_txn(1'b0, 32'hA1B2C3D4, 32'h11223344, 8'h5F, 10, 10, 0, 0, "after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
